model_reader: RTL and testbench
===============================

# model_reader

Draw-command sequencer directly downstream of the model buffer. It accepts one draw command (model id plus an opaque tag) and walks that model's triangles from index 0 by issuing read requests into the model buffer's read port. It forwards each returned triangle, with tag, model id and last-flag, on a registered valid/ready stream to the transform stage. On completion it reports a one-cycle done pulse carrying the triangle count; empty models complete with count 0.

## Interface
- MAX_MODEL_COUNT, 10, model slots in the buffer; model id width MW = $clog2(MAX_MODEL_COUNT)
- MAX_TRIANGLE_COUNT, 512, buffer depth; index/count width IW = $clog2(MAX_TRIANGLE_COUNT)
- TAG_WIDTH, 8, opaque per-draw tag width
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  draw command handshake
- cmd_model_id, cmd_tag  in  MW, TAG_WIDTH  model to draw, tag copied to every output beat
- buf_req_valid / buf_req_ready  out / in  1 / 1  to buffer read_in handshake
- buf_req_model_index, buf_req_triangle_index  out  MW, IW  read address
- buf_resp_valid / buf_resp_ready  in / out  1 / 1  from buffer read_out handshake
- buf_resp_data  in  triangle_t (261)  returned triangle
- buf_resp_last  in  1  buffer's triangle_meta_t.last
- out_valid / out_ready  out / in  1 / 1  triangle stream to downstream
- out_triangle, out_model_id, out_tag, out_last  out  261, MW, TAG_WIDTH, 1  payload
- busy  out  1  high from command accept until done pulse
- done_valid  out  1  one-cycle pulse at end of draw
- done_count  out  IW+1  triangles emitted for the finished draw

## Operation
- FSM states IDLE, REQ, RESP, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid: latch model id and tag, idx<=0, count<=0, go REQ.
- REQ: buf_req_valid=1, address {latched model, idx}. On buf_req_ready go RESP. Otherwise hold request stable.
- RESP (buffer answers exactly one cycle after accepted request, or never for out-of-range index):
  - buf_resp_valid=0: model exhausted. Emit nothing, pulse done with current count, go IDLE.
  - buf_resp_valid=1 and output register free (~out_valid | out_ready): buf_resp_ready=1, load output register, count+1.
    - If buf_resp_last or idx==MAX_TRIANGLE_COUNT-1: set out_last=1 and go DRAIN. The forced last on saturation prevents wrap of idx.
    - Otherwise idx+1, go REQ.
  - Output register occupied and not ready: buf_resp_ready=0, stay in RESP. The buffer holds its data.
- DRAIN: wait for the out_valid&&out_ready handshake of the last beat. Next cycle pulse done_valid, go IDLE.
- One request outstanding at most. The next request is issued only after the previous response is consumed.
- out_* holds stable while out_valid && !out_ready.
- count width is IW+1 so MAX_TRIANGLE_COUNT is representable.
- Reset (any state): FSM to IDLE; idx, count, tag, model latches cleared.

## Timing
- Reset values: cmd_ready=1, buf_req_valid=0, buf_resp_ready=0, out_valid=0, out_last=0, out payload 0, busy=0, done_valid=0, done_count=0.
- cmd accepted at cycle 0: buf_req_valid=1 at cycle 1.
- With buffer and downstream always ready:
  - response at cycle 2, out_valid at cycle 3.
  - Requests at cycles 1,3,5,... giving 1 triangle per 2 cycles.
- Done timing:
  - Empty model: done_valid at cycle 3 with count 0, back in IDLE (cmd_ready=1) at cycle 3.
  - Non-empty model: done_valid one cycle after the last-beat output handshake; cmd_ready reasserts the same cycle.
- cmd_ready=0 whenever busy. A command presented while busy is held by the sender, never dropped.
- Reset asserted mid-draw: outputs take their reset values immediately (asynchronously). No done pulse is emitted for the aborted draw.

## Test plan
- Model 2 holding 3 triangles A,B,C, tag 0x5A, all ready: output A,B,C with out_last 0,0,1, out_tag 0x5A; requests at indices 0,1,2 only; done_count=3; done 1 cycle after C handshake.
- Empty model 4: no out_valid ever; done_valid with done_count=0 at cycle 3 after accept; buf_req issued once at index 0.
- 2-triangle model with out_ready low for 5 cycles on first beat: payload stable throughout; buf_resp_ready=0 while blocked; no second request until first beat consumed; total 2 beats, count 2.
- buf_req_ready low 4 cycles at index 1: buf_req_valid and address stable; sequence otherwise unchanged.
- Second command held valid during draw: cmd_ready=0 until done pulse, then accepted; second draw's tag appears only on its own beats.
- rstn pulsed low after 1 beat of a 5-triangle draw: all outputs to reset values; no done; fresh command afterwards restarts at index 0.

Source files
------------

// File: rtl/model_reader.sv
`default_nettype none
// ============================================================================
// Module   : model_reader
// Purpose  : Draw-command sequencer placed directly after the model buffer.
//            Accepts one draw command (model id + opaque tag), walks the
//            model's triangles from index 0 through the buffer read port and
//            forwards each triangle on a registered valid/ready stream with
//            tag, model id and last flag. Finishes each draw with a one-cycle
//            done pulse carrying the number of triangles emitted.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rstn                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            draw command handshake
//   cmd_model_id, cmd_tag          model to draw, tag copied to each beat
//   buf_req_valid/buf_req_ready    read request to the model buffer
//   buf_req_model_index            read address: model slot
//   buf_req_triangle_index         read address: triangle index
//   buf_resp_valid/buf_resp_ready  read response from the model buffer
//   buf_resp_data, buf_resp_last   returned triangle and its last marker
//   out_valid/out_ready            triangle stream to the transform stage
//   out_triangle, out_model_id,
//   out_tag, out_last              stream payload
//   busy                           high from command accept until done
//   done_valid, done_count         end-of-draw pulse and triangle count
// ============================================================================
module model_reader #(
    parameter int MAX_MODEL_COUNT    = 10,
    parameter int MAX_TRIANGLE_COUNT = 512,
    parameter int TAG_WIDTH          = 8,
    parameter int TRI_WIDTH          = 261,
    localparam int MW                = $clog2(MAX_MODEL_COUNT),
    localparam int IW                = $clog2(MAX_TRIANGLE_COUNT)
) (
    input  logic                 clk,
    input  logic                 rstn,
    // draw command
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [MW-1:0]        cmd_model_id,
    input  logic [TAG_WIDTH-1:0] cmd_tag,
    // model buffer read request
    output logic                 buf_req_valid,
    input  logic                 buf_req_ready,
    output logic [MW-1:0]        buf_req_model_index,
    output logic [IW-1:0]        buf_req_triangle_index,
    // model buffer read response
    input  logic                 buf_resp_valid,
    output logic                 buf_resp_ready,
    input  logic [TRI_WIDTH-1:0] buf_resp_data,
    input  logic                 buf_resp_last,
    // triangle stream
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [TRI_WIDTH-1:0] out_triangle,
    output logic [MW-1:0]        out_model_id,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_last,
    // status
    output logic                 busy,
    output logic                 done_valid,
    output logic [IW:0]          done_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;
    localparam logic [1:0] c_ST_DRAIN = 2'd3;

    localparam logic [IW-1:0] c_IDX_MAX = IW'(MAX_TRIANGLE_COUNT - 1);

    logic [1:0]           state_q, state_d;

    // draw context
    logic [MW-1:0]        model_q, model_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW:0]          count_q, count_d;

    // output register
    logic                 out_valid_q, out_valid_d;
    logic [TRI_WIDTH-1:0] out_tri_q, out_tri_d;
    logic [MW-1:0]        out_model_q, out_model_d;
    logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
    logic                 out_last_q, out_last_d;

    // done reporting
    logic                 done_valid_q, done_valid_d;
    logic [IW:0]          done_count_q, done_count_d;

    // combinational helpers
    logic                 w_out_free;
    logic                 w_force_last;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_exhausted;
    logic                 w_drain_done;

    // The output register can take a new beat when empty or being emptied.
    assign w_out_free   = ~out_valid_q | out_ready;
    // The final addressable index is treated as last so idx can never wrap.
    assign w_force_last = buf_resp_last | (idx_q == c_IDX_MAX);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                if (buf_req_ready) begin
                    state_d = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                // The buffer answers one cycle after the request; silence
                // means the index is past the end of the model.
                if (!buf_resp_valid) begin
                    state_d = c_ST_IDLE;
                end else if (w_out_free) begin
                    state_d = w_force_last ? c_ST_DRAIN : c_ST_REQ;
                end
            end
            c_ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        cmd_ready      = 1'b0;
        buf_req_valid  = 1'b0;
        buf_resp_ready = 1'b0;
        busy           = 1'b1;
        w_accept       = 1'b0;
        w_load         = 1'b0;
        w_exhausted    = 1'b0;
        w_drain_done   = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                w_accept  = cmd_valid;
            end
            c_ST_REQ: begin
                buf_req_valid = 1'b1;
            end
            c_ST_RESP: begin
                // Backpressure the buffer while the output register is full;
                // the buffer keeps presenting the same response.
                buf_resp_ready = buf_resp_valid & w_out_free;
                w_load         = buf_resp_valid & w_out_free;
                w_exhausted    = ~buf_resp_valid;
            end
            c_ST_DRAIN: begin
                w_drain_done = out_valid_q & out_ready;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        model_d      = model_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q & ~out_ready;
        out_tri_d    = out_tri_q;
        out_model_d  = out_model_q;
        out_tag_d    = out_tag_q;
        out_last_d   = out_last_q;
        done_valid_d = w_exhausted | w_drain_done;
        done_count_d = done_count_q;

        if (w_accept) begin
            model_d = cmd_model_id;
            tag_d   = cmd_tag;
            idx_d   = '0;
            count_d = '0;
        end

        if (w_load) begin
            out_valid_d = 1'b1;
            out_tri_d   = buf_resp_data;
            out_model_d = model_q;
            out_tag_d   = tag_q;
            out_last_d  = w_force_last;
            count_d     = count_q + (IW+1)'(1);
            if (!w_force_last) begin
                idx_d = idx_q + IW'(1);
            end
        end

        // count_q already includes the final beat when leaving DRAIN.
        if (done_valid_d) begin
            done_count_d = count_q;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            model_q      <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_tri_q    <= '0;
            out_model_q  <= '0;
            out_tag_q    <= '0;
            out_last_q   <= 1'b0;
            done_valid_q <= 1'b0;
            done_count_q <= '0;
        end else begin
            model_q      <= model_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_tri_q    <= out_tri_d;
            out_model_q  <= out_model_d;
            out_tag_q    <= out_tag_d;
            out_last_q   <= out_last_d;
            done_valid_q <= done_valid_d;
            done_count_q <= done_count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign buf_req_model_index    = model_q;
    assign buf_req_triangle_index = idx_q;
    assign out_valid              = out_valid_q;
    assign out_triangle           = out_tri_q;
    assign out_model_id           = out_model_q;
    assign out_tag                = out_tag_q;
    assign out_last               = out_last_q;
    assign done_valid             = done_valid_q;
    assign done_count             = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_model_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_model_reader
// Purpose  : Scoreboard bench for model_reader. A behavioural model buffer
//            answers read requests one cycle after acceptance; expected beats,
//            requests and done pulses are queued when each draw is issued and
//            a monitor pops and compares them as the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_model_reader;

    localparam int MW  = 4;
    localparam int IW  = 9;
    localparam int TW  = 8;
    localparam int TRW = 261;
    localparam int CW  = 280;

    logic            clk = 1'b0;
    logic            rstn;
    logic            cmd_valid, cmd_ready;
    logic [MW-1:0]   cmd_model_id;
    logic [TW-1:0]   cmd_tag;
    logic            buf_req_valid, buf_req_ready;
    logic [MW-1:0]   buf_req_model_index;
    logic [IW-1:0]   buf_req_triangle_index;
    logic            buf_resp_valid, buf_resp_ready;
    logic [TRW-1:0]  buf_resp_data;
    logic            buf_resp_last;
    logic            out_valid, out_ready;
    logic [TRW-1:0]  out_triangle;
    logic [MW-1:0]   out_model_id;
    logic [TW-1:0]   out_tag;
    logic            out_last;
    logic            busy, done_valid;
    logic [IW:0]     done_count;

    always #5 clk = ~clk;

    model_reader dut (
        .clk                    (clk),
        .rstn                   (rstn),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_model_id           (cmd_model_id),
        .cmd_tag                (cmd_tag),
        .buf_req_valid          (buf_req_valid),
        .buf_req_ready          (buf_req_ready),
        .buf_req_model_index    (buf_req_model_index),
        .buf_req_triangle_index (buf_req_triangle_index),
        .buf_resp_valid         (buf_resp_valid),
        .buf_resp_ready         (buf_resp_ready),
        .buf_resp_data          (buf_resp_data),
        .buf_resp_last          (buf_resp_last),
        .out_valid              (out_valid),
        .out_ready              (out_ready),
        .out_triangle           (out_triangle),
        .out_model_id           (out_model_id),
        .out_tag                (out_tag),
        .out_last               (out_last),
        .busy                   (busy),
        .done_valid             (done_valid),
        .done_count             (done_count)
    );

    typedef struct {
        logic [TRW-1:0] tri_d;
        logic [MW-1:0]  m;
        logic [TW-1:0]  tag;
        logic           last;
    } beat_t;

    typedef struct {
        logic [IW:0] cnt;
        bit          empty;
        bit          chk_first;
    } done_t;

    beat_t              exp_beats[$];
    done_t              exp_done[$];
    logic [MW+IW-1:0]   exp_req[$];

    int n_tests = 0;
    int n_fail  = 0;

    // triangles stored per model slot in the behavioural buffer
    int cnt_tab [10] = '{5, 2, 3, 2, 0, 600, 0, 0, 0, 0};

    // stall controls, set by stimulus and consumed by the buffer driver
    int             out_hold     = 0;
    int             req_hold     = 0;
    logic [IW-1:0]  req_hold_idx = '0;

    // monitor bookkeeping
    int  cyc = 0;
    int  accept_cyc = 0;
    int  last_hs_cyc = 0;
    int  first_beat_cyc = 0;
    int  beats_seen = 0;
    bit  draw_active = 0;
    bit  first_pending = 0;
    bit  outstanding = 0;

    function automatic logic [TRW-1:0] tri_data(input logic [MW-1:0] m, input logic [IW-1:0] i);
        return {i, {12{m, i, 8'hA5}}};
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, what, $time);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model buffer and downstream sink
    // ------------------------------------------------------------------------
    initial begin
        bit            req_p, resp_p;
        logic [MW-1:0] req_m;
        logic [IW-1:0] req_i;
        int            n;
        req_p = 0; resp_p = 0; req_m = '0; req_i = '0;
        buf_req_ready  = 1'b1;
        buf_resp_valid = 1'b0;
        buf_resp_data  = '0;
        buf_resp_last  = 1'b0;
        out_ready      = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                buf_resp_valid = 1'b0;
                req_p  = 0;
                resp_p = 0;
            end else begin
                if (resp_p) buf_resp_valid = 1'b0;
                if (req_p) begin
                    n = (int'(req_m) < 10) ? cnt_tab[req_m] : 0;
                    if (int'(req_i) < n) begin
                        buf_resp_valid = 1'b1;
                        buf_resp_data  = tri_data(req_m, req_i);
                        buf_resp_last  = (int'(req_i) == n - 1);
                    end else begin
                        buf_resp_valid = 1'b0;
                    end
                end
                if (out_hold > 0 && out_valid) begin
                    out_ready = 1'b0;
                    out_hold--;
                end else begin
                    out_ready = 1'b1;
                end
                if (req_hold > 0 && buf_req_valid && buf_req_triangle_index == req_hold_idx) begin
                    buf_req_ready = 1'b0;
                    req_hold--;
                end else begin
                    buf_req_ready = 1'b1;
                end
            end
            #1;
            req_p  = rstn && buf_req_valid && buf_req_ready;
            req_m  = buf_req_model_index;
            req_i  = buf_req_triangle_index;
            resp_p = rstn && buf_resp_valid && buf_resp_ready;
        end
    end

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    initial begin
        bit               prev_ob, prev_rb;
        logic [CW-1:0]    prev_pl;
        logic [MW+IW-1:0] prev_addr, er;
        beat_t            b;
        done_t            d;
        prev_ob = 0; prev_rb = 0; prev_pl = '0; prev_addr = '0;
        forever begin
            @(negedge clk);
            cyc++;
            #1;
            if (!rstn) begin
                prev_ob = 0;
                prev_rb = 0;
                outstanding = 0;
                continue;
            end
            if (done_valid) begin
                if (exp_done.size() == 0) begin
                    fail_now("done_unexpected", $sformatf("got done_count %0d, expected no done pulse", done_count));
                end else begin
                    d = exp_done.pop_front();
                    check("done_count", CW'(done_count), CW'(d.cnt));
                    if (d.empty)
                        check("done_time_empty", CW'(cyc - accept_cyc), CW'(3));
                    else
                        check("done_time", CW'(cyc - last_hs_cyc), CW'(1));
                    if (d.chk_first && !d.empty)
                        check("first_beat_time", CW'(first_beat_cyc - accept_cyc), CW'(3));
                end
                draw_active = 0;
            end
            check("cmd_ready", CW'(cmd_ready), CW'(!draw_active));
            check("busy", CW'(busy), CW'(draw_active));
            if (cmd_valid && cmd_ready) begin
                draw_active   = 1;
                accept_cyc    = cyc;
                first_pending = 1;
                outstanding   = 0;
            end

            if (prev_rb) begin
                check("req_valid_hold", CW'(buf_req_valid), CW'(1));
                check("req_addr_hold", CW'({buf_req_model_index, buf_req_triangle_index}), CW'(prev_addr));
            end
            prev_rb   = buf_req_valid && !buf_req_ready;
            prev_addr = {buf_req_model_index, buf_req_triangle_index};
            if (buf_req_valid && buf_req_ready) begin
                check("one_outstanding", CW'(outstanding), CW'(0));
                if (exp_req.size() == 0) begin
                    fail_now("req_unexpected", $sformatf("got request %0h, expected none", prev_addr));
                end else begin
                    er = exp_req.pop_front();
                    check("req_addr", CW'(prev_addr), CW'(er));
                end
                outstanding = 1;
            end
            if (buf_resp_valid && buf_resp_ready) outstanding = 0;

            if (out_valid && !out_ready && buf_resp_valid)
                check("resp_ready_blocked", CW'(buf_resp_ready), CW'(0));
            if (prev_ob) begin
                check("out_valid_hold", CW'(out_valid), CW'(1));
                check("out_payload_hold", CW'({out_triangle, out_model_id, out_tag, out_last}), prev_pl);
            end
            prev_ob = out_valid && !out_ready;
            prev_pl = CW'({out_triangle, out_model_id, out_tag, out_last});
            if (out_valid && out_ready) begin
                if (exp_beats.size() == 0) begin
                    fail_now("beat_unexpected", $sformatf("got beat tag %0h, expected none", out_tag));
                end else begin
                    b = exp_beats.pop_front();
                    check("out_triangle", CW'(out_triangle), CW'(b.tri_d));
                    check("out_model_id", CW'(out_model_id), CW'(b.m));
                    check("out_tag", CW'(out_tag), CW'(b.tag));
                    check("out_last", CW'(out_last), CW'(b.last));
                end
                beats_seen++;
                if (first_pending) begin
                    first_beat_cyc = cyc;
                    first_pending  = 0;
                end
                if (out_last) last_hs_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic send_cmd(input logic [MW-1:0] m, input logic [TW-1:0] t);
        int k;
        k = 0;
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_model_id = m;
        cmd_tag      = t;
        #1;
        while (!cmd_ready && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!cmd_ready) fail_now("cmd_accept_timeout", "command never accepted");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic draw(input logic [MW-1:0] m, input logic [TW-1:0] t, input int n, input bit chk_first);
        beat_t b;
        done_t d;
        for (int k = 0; k < n; k++) begin
            b.tri_d = tri_data(m, IW'(k));
            b.m     = m;
            b.tag   = t;
            b.last  = (k == n - 1);
            exp_beats.push_back(b);
        end
        for (int k = 0; k < ((n == 0) ? 1 : n); k++) exp_req.push_back({m, IW'(k)});
        d.cnt       = (IW+1)'(n);
        d.empty     = (n == 0);
        d.chk_first = chk_first;
        exp_done.push_back(d);
        send_cmd(m, t);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_beats.size() != 0 || exp_done.size() != 0 || exp_req.size() != 0 || draw_active)
               && k < 3000) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (k >= 3000) fail_now(name, "draw did not complete within cycle budget");
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_cmd_ready"},  CW'(cmd_ready),      CW'(1));
        check({pfx, "_req_valid"},  CW'(buf_req_valid),  CW'(0));
        check({pfx, "_resp_ready"}, CW'(buf_resp_ready), CW'(0));
        check({pfx, "_out_valid"},  CW'(out_valid),      CW'(0));
        check({pfx, "_out_last"},   CW'(out_last),       CW'(0));
        check({pfx, "_payload"},    CW'({out_triangle, out_model_id, out_tag}), CW'(0));
        check({pfx, "_busy"},       CW'(busy),           CW'(0));
        check({pfx, "_done_valid"}, CW'(done_valid),     CW'(0));
        check({pfx, "_done_count"}, CW'(done_count),     CW'(0));
    endtask

    initial begin
        int b0, k;
        rstn         = 1'b0;
        cmd_valid    = 1'b0;
        cmd_model_id = '0;
        cmd_tag      = '0;
        #2;
        check_reset_values("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #2;

        // three triangles, all ready
        draw(4'd2, 8'h5A, 3, 1);
        wait_idle("t1_idle");

        // empty model
        draw(4'd4, 8'h3C, 0, 0);
        wait_idle("t2_idle");

        // first beat blocked downstream for five cycles
        out_hold = 5;
        draw(4'd1, 8'h81, 2, 0);
        wait_idle("t3_idle");

        // request for index 1 stalled for four cycles
        req_hold_idx = 9'd1;
        req_hold     = 4;
        draw(4'd0, 8'h42, 5, 0);
        wait_idle("t4_idle");

        // second command held while the first draw runs
        draw(4'd3, 8'h11, 2, 0);
        draw(4'd1, 8'h22, 2, 0);
        wait_idle("t5_idle");

        // reset after the first beat of a five-triangle draw
        b0 = beats_seen;
        draw(4'd0, 8'h77, 5, 0);
        k = 0;
        while (beats_seen == b0 && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (beats_seen == b0) fail_now("t6_first_beat", "first beat never handshaken");
        @(negedge clk);
        rstn = 1'b0;
        #2;
        check_reset_values("midreset");
        exp_beats.delete();
        exp_done.delete();
        exp_req.delete();
        draw_active = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        draw(4'd0, 8'h33, 5, 1);
        wait_idle("t7_idle");

        // model larger than the buffer depth: last forced at index 511
        draw(4'd5, 8'hC3, 512, 1);
        wait_idle("t8_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
